// File: rtl/conv_mac_accumulator.sv
// conv_mac_accumulator
//   Two-stage multiply/accumulate that sits behind the convolution checker.
//   Stage 1 registers the signed product of the IF and filter words read this
//   cycle, stage 2 folds filter_size products into one partial sum, and a
//   single output register hands each sum downstream over valid/ready.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   start, filter_size        begin a run; latch products per sum (0 -> 1)
//   can_mult, if_data,
//   filter_data               operand pair from the checker
//   par_done                  close the current window early
//   Done                      checker has issued its last can_mult
//   mac_ready                 can_mult is accepted this cycle
//   psum_out, psum_valid,
//   psum_ready                partial-sum handshake to the psum buffer
//   busy, mac_done            run status / one-cycle completion pulse
//   sat_flag                  sticky saturation indicator (MAC_SATURATE_EN only)
//
// Build option: define MAC_SATURATE_EN for saturating accumulation and the
// sat_flag port; otherwise the accumulator wraps modulo 2^PSUM_SIZE.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting products from the checker
// DRAIN | Done seen; emptying both stages and the output register

module conv_mac_accumulator #(
   parameter int IF_CELL_SIZE     = 8,
   parameter int FILTER_CELL_SIZE = 8,
   parameter int PSUM_SIZE        = 20
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [2:0]                  filter_size,
   input  logic                        can_mult,
   input  logic [IF_CELL_SIZE-1:0]     if_data,
   input  logic [FILTER_CELL_SIZE-1:0] filter_data,
   input  logic                        par_done,
   input  logic                        Done,
   output logic                        mac_ready,
   output logic [PSUM_SIZE-1:0]        psum_out,
   output logic                        psum_valid,
   input  logic                        psum_ready,
   output logic                        busy,
   output logic                        mac_done
`ifdef MAC_SATURATE_EN
   ,
   output logic                        sat_flag
`endif
);

   localparam int MW = IF_CELL_SIZE + FILTER_CELL_SIZE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [2:0]                  n_q;
   logic [2:0]                  n_start;
   logic [2:0]                  remain_q;
   logic signed [MW-1:0]        a_ext, b_ext, prod;
   logic signed [PSUM_SIZE-1:0] prod_ext;
   logic signed [PSUM_SIZE-1:0] p_reg;
   logic signed [PSUM_SIZE-1:0] acc;
   logic signed [PSUM_SIZE-1:0] add_res;
   logic signed [PSUM_SIZE-1:0] acc_sum;
   logic signed [PSUM_SIZE-1:0] sum_sel;
   logic                        p_valid;
   logic                        p_par;
   logic                        flush_pend;
   logic                        start_ok;
   logic                        accept;
   logic                        first;
   logic                        last_prod;
   logic                        standalone;
   logic                        flush_req;
   logic                        flush_close;
   logic                        close;
   logic                        stall;

   // Full-precision product always fits in IF+FILTER bits, then sign-extended.
   assign a_ext    = MW'($signed(if_data));
   assign b_ext    = MW'($signed(filter_data));
   assign prod     = a_ext * b_ext;
   assign prod_ext = PSUM_SIZE'(prod);

   assign n_start  = (filter_size == 3'd0) ? 3'd1 : filter_size;
   assign start_ok = start && (state_q == IDLE);

`ifdef MAC_SATURATE_EN
   localparam logic signed [PSUM_SIZE-1:0] SAT_MAX = {1'b0, {(PSUM_SIZE-1){1'b1}}};
   localparam logic signed [PSUM_SIZE-1:0] SAT_MIN = {1'b1, {(PSUM_SIZE-1){1'b0}}};

   logic signed [PSUM_SIZE:0] add_w;
   logic                      add_ovf;

   assign add_w   = (PSUM_SIZE+1)'(acc) + (PSUM_SIZE+1)'(p_reg);
   assign add_ovf = add_w[PSUM_SIZE] ^ add_w[PSUM_SIZE-1];
   assign add_res = add_ovf ? (add_w[PSUM_SIZE] ? SAT_MIN : SAT_MAX)
                            : add_w[PSUM_SIZE-1:0];
`else
   assign add_res = acc + p_reg;
`endif

   // remain_q counts down the products still missing from the open window;
   // it equals n_q while the window is empty.
   always_comb begin
      first       = (remain_q == n_q);
      last_prod   = p_valid && ((remain_q == 3'd1) || p_par);
      acc_sum     = first ? p_reg : add_res;
      // par_done without an operand pair is a window flush rather than a tag.
      standalone  = par_done && !can_mult && (state_q != IDLE);
      flush_req   = (flush_pend || standalone) && !p_valid;
      flush_close = flush_req && !first;
      close       = last_prod || flush_close;
      sum_sel     = last_prod ? acc_sum : acc;
      stall       = close && psum_valid && !psum_ready;
      // A pending flush must finish before any newer product enters stage 2.
      mac_ready   = (state_q == RUN) && !stall && !flush_pend;
      accept      = can_mult && mac_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      mac_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (Done) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!p_valid && !flush_pend && !close && !psum_valid) begin
               state_d  = IDLE;
               mac_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage 1: multiply.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_reg   <= '0;
         p_valid <= 1'b0;
         p_par   <= 1'b0;
      end else if (start_ok) begin
         p_reg   <= '0;
         p_valid <= 1'b0;
         p_par   <= 1'b0;
      end else if (accept) begin
         p_reg   <= prod_ext;
         p_valid <= 1'b1;
         p_par   <= par_done;
      end else if (!stall) begin
         p_valid <= 1'b0;
         p_par   <= 1'b0;
      end
   end

   // Stage 2: accumulate and close windows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc        <= '0;
         n_q        <= '0;
         remain_q   <= '0;
         flush_pend <= 1'b0;
      end else if (start_ok) begin
         acc        <= '0;
         n_q        <= n_start;
         remain_q   <= n_start;
         flush_pend <= 1'b0;
      end else begin
         if (p_valid && !stall) begin
            acc      <= acc_sum;
            remain_q <= last_prod ? n_q : (remain_q - 3'd1);
         end else if (flush_req && !stall) begin
            remain_q <= n_q;
         end
         flush_pend <= (flush_pend || standalone) && !(flush_req && !stall);
      end
   end

   // Output register: may reload in the same cycle its sum is consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         psum_out   <= '0;
         psum_valid <= 1'b0;
      end else if (close && !stall) begin
         psum_out   <= sum_sel;
         psum_valid <= 1'b1;
      end else if (psum_valid && psum_ready) begin
         psum_valid <= 1'b0;
      end
   end

`ifdef MAC_SATURATE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_flag <= 1'b0;
      end else if (start_ok) begin
         sat_flag <= 1'b0;
      end else if (p_valid && !stall && !first && add_ovf) begin
         sat_flag <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_mac_accumulator.sv
module tb_conv_mac_accumulator;

   localparam int PW   = 16;
   localparam int SMAX = 32767;
   localparam int SMIN = -32768;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    filter_size;
   logic          can_mult;
   logic [7:0]    if_data;
   logic [7:0]    filter_data;
   logic          par_done;
   logic          Done;
   logic          mac_ready;
   logic [PW-1:0] psum_out;
   logic          psum_valid;
   logic          psum_ready;
   logic          busy;
   logic          mac_done;
`ifdef MAC_SATURATE_EN
   logic          sat_flag;
`endif

   conv_mac_accumulator #(
      .IF_CELL_SIZE(8), .FILTER_CELL_SIZE(8), .PSUM_SIZE(PW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .filter_size(filter_size),
      .can_mult(can_mult), .if_data(if_data), .filter_data(filter_data),
      .par_done(par_done), .Done(Done), .mac_ready(mac_ready),
      .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready),
      .busy(busy), .mac_done(mac_done)
`ifdef MAC_SATURATE_EN
      , .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   int            done_pulses = 0;
   int            deliveries = 0;
   int            n_model = 1;
   bit            run_active = 0;
   int            win[$];
   logic [PW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: a window is the list of its products; its sum is their
   // running total, clamped per step when saturating, else taken mod 2^PW.
   task automatic close_window();
      int s;
      s = 0;
      for (int i = 0; i < win.size(); i++) begin
         if (i == 0) s = win[i];
         else begin
            s += win[i];
`ifdef MAC_SATURATE_EN
            if (s > SMAX) s = SMAX;
            else if (s < SMIN) s = SMIN;
`endif
         end
      end
      exp_q.push_back(s[PW-1:0]);
      win.delete();
   endtask

   task automatic step(input bit cm, input int a, input int b, input bit pd,
                       input bit pr, input bit dn, output bit took);
      @(negedge clk);
      start       = 1'b0;
      can_mult    = cm;
      if_data     = a[7:0];
      filter_data = b[7:0];
      par_done    = pd;
      psum_ready  = pr;
      Done        = dn;
      #1;
      took = cm && mac_ready;
      if (mac_done) done_pulses++;
      if (psum_valid && psum_ready) begin
         deliveries++;
         chk("psum_expected_pending", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            chk("psum_value", psum_out, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
      if (took) begin
         win.push_back(a * b);
         if (win.size() == n_model || pd) close_window();
      end else if (!cm && pd && run_active && win.size() > 0) begin
         close_window();
      end
   endtask

   task automatic begin_run(input int fs);
      @(negedge clk);
      start       = 1'b1;
      filter_size = fs[2:0];
      can_mult    = 1'b0;
      par_done    = 1'b0;
      Done        = 1'b0;
      psum_ready  = 1'b1;
      n_model     = (fs == 0) ? 1 : fs;
      win.delete();
      run_active  = 1;
      done_pulses = 0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      bit t;
      n = 0;
      while (done_pulses == 0 && n < 100) begin
         step(0, 0, 0, 0, 1, 0, t);
         n++;
      end
      step(0, 0, 0, 0, 1, 0, t);
      step(0, 0, 0, 0, 1, 0, t);
      chk({tag, "_mac_done_once"}, done_pulses, 1);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_all_sums_out"}, exp_q.size(), 0);
      run_active = 0;
   endtask

   task automatic end_run(input string tag);
      bit t;
      step(0, 0, 0, 0, 1, 1, t);
      wait_done(tag);
   endtask

   initial begin
      bit t;
      int cyc, i, d0, a, b;
      int va[4];
      int vb[4];

      rst = 1'b0; start = 0; filter_size = 0; can_mult = 0; if_data = 0;
      filter_data = 0; par_done = 0; Done = 0; psum_ready = 0;
      #2;
      chk("rst_psum_valid", psum_valid, 0);
      chk("rst_psum_out", psum_out, 0);
      chk("rst_mac_ready", mac_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mac_done", mac_done, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      // Basic window of three.
      begin_run(3);
      step(1, 2, 3, 0, 1, 0, t);  chk("basic_acc1", t, 1);
      step(1, 4, -1, 0, 1, 0, t); chk("basic_acc2", t, 1);
      step(1, 5, 5, 0, 1, 0, t);  chk("basic_acc3", t, 1);
      step(0, 0, 0, 0, 1, 0, t);  chk("basic_lat1_valid", psum_valid, 0);
      step(0, 0, 0, 0, 1, 0, t);  chk("basic_lat2_valid", psum_valid, 1);
      chk("basic_sum", psum_out, 27);
      step(0, 0, 0, 0, 1, 0, t);  chk("basic_single_cycle", psum_valid, 0);
      end_run("basic");

      // Back-pressure with single-product windows.
      va = '{3, -7, 100, -128}; vb = '{5, 9, -2, -128};
      begin_run(1);
      d0 = deliveries; i = 0; cyc = 0;
      while (i < 4 && cyc < 50) begin
         step(1, va[i], vb[i], 0, (cyc >= 6), 0, t);
         if (cyc == 2) chk("bp_mac_ready_low", t, 0);
         if (t) i++;
         cyc++;
      end
      chk("bp_all_accepted", i, 4);
      end_run("bp");
      chk("bp_delivered", deliveries - d0, 4);

      // Early close, restart, standalone flushes.
      begin_run(5);
      step(1, 7, 7, 0, 0, 0, t);
      step(1, 1, 1, 1, 0, 0, t);
      step(0, 0, 0, 0, 0, 0, t);
      step(0, 0, 0, 0, 0, 0, t);
      chk("pd_valid", psum_valid, 1);
      chk("pd_sum", psum_out, 50);
      for (int k = 0; k < 5; k++) step(1, 1, 2, 0, 1, 0, t);
      step(0, 0, 0, 0, 1, 0, t);
      step(0, 0, 0, 0, 1, 0, t);
      chk("pd_restart_sum", psum_out, 10);
      step(1, 3, 3, 0, 1, 0, t);
      step(1, 2, 2, 0, 1, 0, t);
      step(0, 0, 0, 1, 1, 0, t);
      step(0, 0, 0, 0, 1, 0, t);
      step(0, 0, 0, 0, 1, 0, t);
      chk("pd_flush_sum", psum_out, 13);
      d0 = deliveries;
      step(0, 0, 0, 1, 1, 0, t);
      step(0, 0, 0, 0, 1, 0, t);
      step(0, 0, 0, 0, 1, 0, t);
      chk("pd_empty_no_sum", deliveries - d0, 0);
      end_run("pd");

      // Done with the final product, output held back for three cycles.
      begin_run(2);
      step(1, 2, 2, 0, 1, 0, t);
      step(1, 5, 5, 0, 0, 1, t);  chk("done_last_accepted", t, 1);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 0, 0, t);
         chk("done_busy_held", busy, 1);
      end
      chk("done_held_sum", psum_out, 29);
      wait_done("done");

      // Overflow.
      begin_run(7);
      for (int k = 0; k < 7; k++) step(1, 127, 127, 0, 0, 0, t);
      step(0, 0, 0, 0, 0, 0, t);
      step(0, 0, 0, 0, 0, 0, t);
      chk("ovf_valid", psum_valid, 1);
`ifdef MAC_SATURATE_EN
      chk("ovf_sum", psum_out, 32767);
      chk("ovf_sat_flag", sat_flag, 1);
`else
      chk("ovf_sum", psum_out, 47367);
`endif
      end_run("ovf");

      // Randomized runs.
      for (int r = 0; r < 6; r++) begin
         begin_run($urandom_range(0, 7));
         for (int k = 0; k < 30; k++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            step(($urandom_range(0, 3) != 0), a, b, ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1), 0, t);
         end
         end_run("rand");
      end

      // Reset in the middle of a run.
      begin_run(1);
      step(1, 3, 4, 0, 0, 0, t);
      step(1, 2, 2, 0, 0, 0, t);
      step(0, 0, 0, 0, 0, 0, t);
      chk("mid_pre_valid", psum_valid, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_psum_valid", psum_valid, 0);
      chk("mid_rst_psum_out", psum_out, 0);
      chk("mid_rst_mac_ready", mac_ready, 0);
      exp_q.delete(); win.delete(); run_active = 0; done_pulses = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0, t);
      chk("mid_no_mac_done", done_pulses, 0);
      chk("mid_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
